pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/pipeline_hazard_ctrl_match.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: stage tags,
// forwarding selects and stall FSM states.
package pipeline_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] rn;
    logic       rn_used;
    logic [4:0] rm;
    logic       rm_used;
  } stage_tag_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_match.sv
// hazard_match: does a tracked producer tag write a given source?
// XZR never matches on either side.
module hazard_match
  import pipeline_pkg::*;
(
  input  stage_tag_t i_tag,
  input  logic [4:0] i_src,
  input  logic       i_used,
  output logic       o_match
);

  logic w_unused;

  assign o_match = i_tag.valid & i_tag.regwrite & i_used &
                   (i_tag.rd == i_src) & (i_tag.rd != XZR);

  assign w_unused = ^{i_tag.memtoreg, i_tag.rn, i_tag.rn_used,
                      i_tag.rm, i_tag.rm_used};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection, forwarding select and stall/flush control.
// Define HAZARD_FWD_EN for forwarding; otherwise stall-only interlock.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_rn_used,
  input  logic       id_rm_used,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_memtoreg,
  input  logic       ex_branch_taken,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       idex_bubble,
  output logic       flush_ifid,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  stage_tag_t r_ex, r_mem, r_wb, w_id_tag;
  hz_state_t  r_state, w_state_n;
  logic [1:0] r_cnt, w_cnt_n;
  logic       w_stall, w_hz, w_enter;
  logic       w_ex_rn, w_ex_rm;
  fwd_sel_t   w_fwd_a, w_fwd_b;
  logic       w_unused;

  always_comb begin
    w_id_tag          = '0;
    w_id_tag.valid    = id_valid;
    w_id_tag.rd       = id_rd;
    w_id_tag.regwrite = id_regwrite;
    w_id_tag.memtoreg = id_memtoreg;
    w_id_tag.rn       = id_rn;
    w_id_tag.rn_used  = id_rn_used;
    w_id_tag.rm       = id_rm;
    w_id_tag.rm_used  = id_rm_used;
  end

  hazard_match u_ex_rn (
    .i_tag(r_ex), .i_src(id_rn),
    .i_used(id_rn_used), .o_match(w_ex_rn)
  );
  hazard_match u_ex_rm (
    .i_tag(r_ex), .i_src(id_rm),
    .i_used(id_rm_used), .o_match(w_ex_rm)
  );

`ifdef HAZARD_FWD_EN
  logic w_mem_a, w_mem_b, w_wb_a, w_wb_b;

  hazard_match u_mem_a (
    .i_tag(r_mem), .i_src(r_ex.rn),
    .i_used(r_ex.rn_used), .o_match(w_mem_a)
  );
  hazard_match u_mem_b (
    .i_tag(r_mem), .i_src(r_ex.rm),
    .i_used(r_ex.rm_used), .o_match(w_mem_b)
  );
  hazard_match u_wb_a (
    .i_tag(r_wb), .i_src(r_ex.rn),
    .i_used(r_ex.rn_used), .o_match(w_wb_a)
  );
  hazard_match u_wb_b (
    .i_tag(r_wb), .i_src(r_ex.rm),
    .i_used(r_ex.rm_used), .o_match(w_wb_b)
  );

  // Only a load in EX cannot be forwarded in time
  assign w_hz    = id_valid & r_ex.memtoreg & (w_ex_rn | w_ex_rm);
  assign w_enter = 1'b0;
  assign w_fwd_a = w_mem_a ? FWD_EXMEM : (w_wb_a ? FWD_MEMWB : FWD_REG);
  assign w_fwd_b = w_mem_b ? FWD_EXMEM : (w_wb_b ? FWD_MEMWB : FWD_REG);
`else
  logic w_mem_rn, w_mem_rm;

  hazard_match u_mem_rn (
    .i_tag(r_mem), .i_src(id_rn),
    .i_used(id_rn_used), .o_match(w_mem_rn)
  );
  hazard_match u_mem_rm (
    .i_tag(r_mem), .i_src(id_rm),
    .i_used(id_rm_used), .o_match(w_mem_rm)
  );

  // WB needs no interlock: the register file writes before it reads
  assign w_hz    = id_valid & (w_ex_rn | w_ex_rm | w_mem_rn | w_mem_rm);
  assign w_enter = id_valid & (w_ex_rn | w_ex_rm);
  assign w_fwd_a = FWD_REG;
  assign w_fwd_b = FWD_REG;
`endif

  assign w_unused = ^r_wb;

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_stall     = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush_ifid  = 1'b0;
    fwd_a       = w_fwd_a;
    fwd_b       = w_fwd_b;
    unique case (r_state)
      RUN: begin
        w_stall = w_hz;
        if (w_enter) begin
          w_state_n = STALL;
          w_cnt_n   = 2'd1;
        end
      end
      STALL: begin
        w_stall = id_valid;
        if (r_cnt <= 2'd1) begin
          w_state_n = RUN;
          w_cnt_n   = 2'd0;
        end else begin
          w_cnt_n = r_cnt - 2'd1;
        end
      end
      default: w_state_n = RUN;
    endcase
    if (w_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
    if (ex_branch_taken) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b1;
      flush_ifid  = 1'b1;
      w_state_n   = RUN;
      w_cnt_n     = 2'd0;
    end
    if (reset) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      flush_ifid  = 1'b0;
      fwd_a       = FWD_REG;
      fwd_b       = FWD_REG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_wb    <= r_mem;
      r_mem   <= r_ex;
      if (idex_bubble || !id_valid) r_ex <= '0;
      else                          r_ex <= w_id_tag;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (vectors follow HAZARD_FWD_EN).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rn = '0, id_rm = '0, id_rd = '0;
  logic       id_rn_used = 1'b0, id_rm_used = 1'b0;
  logic       id_regwrite = 1'b0, id_memtoreg = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       pc_write, ifid_write, idex_bubble, flush_ifid;
  logic [1:0] fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_exp[$];
  string      q_name[$];

  // {pc_write, ifid_write, idex_bubble, flush_ifid, fwd_a, fwd_b}
  localparam logic [7:0] NORM  = 8'b1100_0000;
  localparam logic [7:0] STL   = 8'b0010_0000;
  localparam logic [7:0] FLUSH = 8'b1111_0000;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg),
    .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .flush_ifid(flush_ifid),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  task automatic step(input string nm, input logic rst,
                      input logic v, input logic [4:0] rn,
                      input logic rnu, input logic [4:0] rm,
                      input logic rmu, input logic [4:0] rd,
                      input logic rw, input logic ld,
                      input logic br, input logic [7:0] exp);
    @(posedge clk);
    #1;
    reset = rst; id_valid = v;
    id_rn = rn; id_rn_used = rnu;
    id_rm = rm; id_rm_used = rmu;
    id_rd = rd; id_regwrite = rw;
    id_memtoreg = ld; ex_branch_taken = br;
    q_exp.push_back(exp);
    q_name.push_back(nm);
  endtask

  task automatic idle(input string nm, input logic [7:0] exp);
    step(nm, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
         5'd0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  // producer: rd <= f(X20, X21)
  task automatic prod(input string nm, input logic [4:0] rd,
                      input logic ld, input logic [7:0] exp);
    step(nm, 1'b0, 1'b1, 5'd20, 1'b1, 5'd21, !ld,
         rd, 1'b1, ld, 1'b0, exp);
  endtask

  // consumer: X9 <= f(rn, rm)
  task automatic cons(input string nm, input logic [4:0] rn,
                      input logic [4:0] rm, input logic rmu,
                      input logic br, input logic [7:0] exp);
    step(nm, 1'b0, 1'b1, rn, 1'b1, rm, rmu,
         5'd9, 1'b1, 1'b0, br, exp);
  endtask

  always @(negedge clk) begin
    logic [7:0] act, exp;
    string nm;
    if (q_exp.size() > 0) begin
      exp = q_exp.pop_front();
      nm  = q_name.pop_front();
      act = {pc_write, ifid_write, idex_bubble, flush_ifid,
             fwd_a, fwd_b};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %b want %b", nm, act, exp);
      end
    end
  end

  initial begin
    step("rst0", 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
         5'd0, 1'b0, 1'b0, 1'b0, NORM);
    step("rst1", 1'b1, 1'b1, 5'd1, 1'b1, 5'd1, 1'b1,
         5'd1, 1'b1, 1'b1, 1'b0, NORM);
    idle("idle0", NORM);
`ifdef HAZARD_FWD_EN
    prod("adds_x1", 5'd1, 1'b0, NORM);
    cons("use_x1", 5'd1, 5'd3, 1'b1, 1'b0, NORM);
    idle("fwd_exmem", 8'b1100_1000);
    prod("ldur_x4", 5'd4, 1'b1, NORM);
    cons("lu_stall", 5'd4, 5'd0, 1'b0, 1'b0, STL);
    cons("lu_release", 5'd4, 5'd0, 1'b0, 1'b0, NORM);
    idle("fwd_memwb", 8'b1100_0100);
    prod("addi_x31", 5'd31, 1'b0, NORM);
    cons("use_x31", 5'd31, 5'd31, 1'b1, 1'b0, NORM);
    idle("x31_nofwd", NORM);
    prod("ldur_x4b", 5'd4, 1'b1, NORM);
    cons("br_flush", 5'd4, 5'd0, 1'b0, 1'b1, FLUSH);
    idle("after_flush", NORM);
    prod("adds_x1b", 5'd1, 1'b0, NORM);
    prod("adds_x2", 5'd2, 1'b0, NORM);
    cons("use_x1_x2", 5'd1, 5'd2, 1'b1, 1'b0, NORM);
    idle("fwd_split", 8'b1100_0110);
    prod("adds_x3a", 5'd3, 1'b0, NORM);
    prod("adds_x3b", 5'd3, 1'b0, NORM);
    cons("use_x3", 5'd3, 5'd0, 1'b0, 1'b0, NORM);
    idle("mem_prio", 8'b1100_1000);
`else
    prod("adds_x1", 5'd1, 1'b0, NORM);
    cons("ex_stall1", 5'd1, 5'd3, 1'b1, 1'b0, STL);
    cons("ex_stall2", 5'd1, 5'd3, 1'b1, 1'b0, STL);
    cons("ex_release", 5'd1, 5'd3, 1'b1, 1'b0, NORM);
    idle("idle1", NORM);
    prod("adds_x7", 5'd7, 1'b0, NORM);
    prod("adds_x8", 5'd8, 1'b0, NORM);
    cons("mem_stall", 5'd7, 5'd0, 1'b0, 1'b0, STL);
    cons("mem_release", 5'd7, 5'd0, 1'b0, 1'b0, NORM);
    prod("addi_x31", 5'd31, 1'b0, NORM);
    cons("use_x31", 5'd31, 5'd31, 1'b1, 1'b0, NORM);
    prod("adds_x4", 5'd4, 1'b0, NORM);
    cons("br_flush", 5'd4, 5'd0, 1'b0, 1'b1, FLUSH);
    cons("post_br_mem", 5'd4, 5'd0, 1'b0, 1'b0, STL);
    cons("post_br_run", 5'd4, 5'd0, 1'b0, 1'b0, NORM);
    prod("adds_x5", 5'd5, 1'b0, NORM);
    step("id_invalid", 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1,
         5'd9, 1'b1, 1'b0, 1'b0, NORM);
    cons("x5_in_mem", 5'd5, 5'd0, 1'b0, 1'b0, STL);
    cons("x5_release", 5'd5, 5'd0, 1'b0, 1'b0, NORM);
    prod("adds_x6", 5'd6, 1'b0, NORM);
    cons("rm_stall1", 5'd10, 5'd6, 1'b1, 1'b0, STL);
    cons("rm_stall2", 5'd10, 5'd6, 1'b1, 1'b0, STL);
    cons("rm_release", 5'd10, 5'd6, 1'b1, 1'b0, NORM);
    prod("adds_x6b", 5'd6, 1'b0, NORM);
    cons("rm_unused", 5'd10, 5'd6, 1'b0, 1'b0, NORM);
    idle("idle2", NORM);
    prod("adds_x1c", 5'd1, 1'b0, NORM);
    cons("pre_rst_stall", 5'd1, 5'd0, 1'b0, 1'b0, STL);
    step("rst_mid", 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0,
         5'd9, 1'b1, 1'b0, 1'b0, NORM);
    cons("post_rst_run", 5'd1, 5'd0, 1'b0, 1'b0, NORM);
`endif
    @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
